// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data RAM between the CPU MEM stage and a
//               DMA/IO requester. The CPU has priority, with an anti-starvation
//               forced DMA slot.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        S_CPU   = 1'b0,
        S_FORCE = 1'b1
    } state_t;

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    state_t                  state_q, state_d;
    logic [3:0]              starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0]   dma_rdata_q;
    logic                    dma_rvalid_q;

    logic                    w_cpu_req;
    logic                    w_cpu_own;
    logic                    w_dma_own;
    logic                    w_stall;
    logic                    w_dma_rd;

    assign w_cpu_req = cpu_re | cpu_we;
    assign w_dma_rd  = w_dma_own & ~dma_we;

    // Ownership, stall and starvation bookkeeping
    always_comb begin
        w_cpu_own    = 1'b0;
        w_dma_own    = 1'b0;
        w_stall      = 1'b0;
        state_d      = S_CPU;
        starve_cnt_d = '0;
        case (state_q)
            S_CPU: begin
                if (w_cpu_req) begin
                    w_cpu_own = 1'b1;
                    if (dma_req) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                        if (starve_cnt_d == C_LIMIT) begin
                            state_d = S_FORCE;
                        end
                    end
                end else if (dma_req) begin
                    w_dma_own = 1'b1;
                end
            end
            S_FORCE: begin
                // A dropped request leaves the slot idle, but the CPU still loses it.
                w_dma_own = dma_req;
                w_stall   = w_cpu_req;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    // RAM bus steering; everything is forced low while reset is held
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        dma_gnt   = 1'b0;
        if (!reset) begin
            cpu_stall = w_stall;
            dma_gnt   = w_dma_own;
            if (w_cpu_own) begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                mem_re    = cpu_re & ~cpu_we;
                cpu_rdata = mem_rdata;
            end else if (w_dma_own) begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we;
                mem_re    = ~dma_we;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CPU;
            starve_cnt_q <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dma_rvalid_q <= w_dma_rd;
            if (w_dma_rd) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule
`default_nettype wire
